// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding, register constants and hazard priority shared by the pipeline controller and the forwarding unit.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic [1:0] {PRIO_NONE, PRIO_LU, PRIO_MP, PRIO_BUSY} prio_e;
  function automatic prio_e prio_sel(input logic busy, input logic mp, input logic lu);
    return busy ? PRIO_BUSY : mp ? PRIO_MP : lu ? PRIO_LU : PRIO_NONE;
  endfunction
endpackage

// File: rtl/pipeline_hazard_detect.sv
// hazard_detect: combinational load-use and branch-mispredict detection.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_rd_memory_i,
  input  logic       ex_is_branch_i,
  input  logic       ex_taken_i,
  input  logic       ex_prediction_i,
  output logic       lu_o,
  output logic       mp_o
);
  assign lu_o = id_valid_i & ex_valid_i & ex_rd_memory_i & (ex_rd_i != REG_ZERO) &
                ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) | (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
  assign mp_o = ex_valid_i & ex_is_branch_i & (ex_taken_i != ex_prediction_i);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: drives stage-latch hold/squash, PC enable and redirect, and counts stall and flush events.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_HOLD = 1,
  parameter int CNT_W      = 16
) (
  input  logic             stg_clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rd_memory,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic             ex_prediction,
  input  logic             mem_busy,
  output logic             pc_ena,
  output logic             redirect,
  output logic             if_id_ena,
  output logic             if_id_x,
  output logic             id_ex_ena,
  output logic             id_ex_x,
  output logic             ex_mem_ena,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_e           state_q, state_d;
  logic [2:0]       hold_q, hold_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             lu, mp;
  prio_e            prio;
  hazard_detect u_det (
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_rd_memory_i(ex_rd_memory),
    .ex_is_branch_i(ex_is_branch), .ex_taken_i(ex_taken), .ex_prediction_i(ex_prediction),
    .lu_o(lu), .mp_o(mp)
  );
  assign prio      = prio_sel(mem_busy, mp, lu);
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  // Load-use in INIT/FLUSH is dropped: decode already holds a bubble there.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    pc_ena     = 1'b1;
    redirect   = 1'b0;
    if_id_ena  = 1'b1;
    if_id_x    = 1'b0;
    id_ex_ena  = 1'b1;
    id_ex_x    = 1'b0;
    ex_mem_ena = 1'b1;
    if (prio == PRIO_BUSY) begin
      pc_ena     = 1'b0;
      if_id_ena  = 1'b0;
      id_ex_ena  = 1'b0;
      ex_mem_ena = 1'b0;
    end else if (prio == PRIO_MP) begin
      redirect = 1'b1;
      if_id_x  = 1'b1;
      id_ex_x  = 1'b1;
      flush_d  = &flush_q ? flush_q : flush_q + CNT_W'(1);
      hold_d   = 3'(FLUSH_HOLD);
      state_d  = (FLUSH_HOLD == 0) ? RUN : FLUSH;
    end else if (state_q == INIT) begin
      if_id_x = 1'b1;
      id_ex_x = 1'b1;
      state_d = RUN;
    end else if (state_q == FLUSH) begin
      if_id_x = 1'b1;
      hold_d  = hold_q - 3'd1;
      state_d = (hold_q == 3'd1) ? RUN : FLUSH;
    end else if (prio == PRIO_LU) begin
      pc_ena    = 1'b0;
      if_id_ena = 1'b0;
      id_ex_x   = 1'b1;
      stall_d   = &stall_q ? stall_q : stall_q + CNT_W'(1);
    end
  end
  always_ff @(posedge stg_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      hold_q  <= 3'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus with a cycle-level behavioural model and hand-computed checkpoints.
module tb_pipeline_hazard_ctrl;
  localparam int FH = 2;
  localparam int CW = 4;
  logic          stg_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          id_valid, id_rs1_used, id_rs2_used, ex_valid, ex_rd_memory;
  logic          ex_is_branch, ex_taken, ex_prediction, mem_busy;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          pc_ena, redirect, if_id_ena, if_id_x, id_ex_ena, id_ex_x, ex_mem_ena;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    outs;
  int            n_vec = 0;
  int            n_err = 0;
  pipeline_hazard_ctrl #(.FLUSH_HOLD(FH), .CNT_W(CW)) dut (
    .stg_clk(stg_clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_rd_memory(ex_rd_memory), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_prediction(ex_prediction), .mem_busy(mem_busy), .pc_ena(pc_ena), .redirect(redirect),
    .if_id_ena(if_id_ena), .if_id_x(if_id_x), .id_ex_ena(id_ex_ena), .id_ex_x(id_ex_x),
    .ex_mem_ena(ex_mem_ena), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 stg_clk = ~stg_clk;
  assign outs = {pc_ena, redirect, if_id_ena, if_id_x, id_ex_ena, id_ex_x, ex_mem_ena};
  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask
  // Model: remaining flush cycles, pending INIT cycle and unbounded counts clipped at 15.
  bit m_init = 1'b1;
  int m_left = 0;
  int m_sc   = 0;
  int m_fc   = 0;
  always @(negedge stg_clk) begin
    bit         mp_c, lu_c;
    logic [6:0] e;
    if (!reset_n) begin
      m_init = 1'b1;
      m_left = 0;
      m_sc   = 0;
      m_fc   = 0;
    end else begin
      mp_c = ex_valid && ex_is_branch && (ex_taken != ex_prediction);
      lu_c = id_valid && ex_valid && ex_rd_memory && ex_rd != 0 &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
      chk("model_stall_cnt", int'(stall_cnt), m_sc);
      chk("model_flush_cnt", int'(flush_cnt), m_fc);
      e = 7'b1010101;
      if (mem_busy) e = 7'b0000000;
      else if (mp_c) begin
        e = 7'b1111111;
        m_fc = (m_fc + 1 > 15) ? 15 : m_fc + 1;
        m_left = FH;
        m_init = 1'b0;
      end else if (m_init) begin
        e = 7'b1011111;
        m_init = 1'b0;
      end else if (m_left > 0) begin
        e = 7'b1011101;
        m_left--;
      end else if (lu_c) begin
        e = 7'b0000111;
        m_sc = (m_sc + 1 > 15) ? 15 : m_sc + 1;
      end
      chk("model_outs", int'(outs), int'(e));
    end
  end
  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_valid = 0; ex_rd = 0; ex_rd_memory = 0; ex_is_branch = 0; ex_taken = 0;
    ex_prediction = 0; mem_busy = 0;
  endtask
  task automatic lu_set(input logic [4:0] rd, input logic [4:0] rs);
    ex_valid = 1; ex_rd_memory = 1; ex_rd = rd;
    id_valid = 1; id_rs2_used = 1; id_rs2 = rs;
  endtask
  task automatic mp_set();
    ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_prediction = 0;
  endtask
  task automatic tick();
    @(posedge stg_clk);
    #1;
  endtask
  initial begin
    idle();
    repeat (2) @(posedge stg_clk);
    #1 reset_n = 1'b1;
    #5 chk("init_if_id_x", if_id_x, 1);
    chk("init_id_ex_x", id_ex_x, 1);
    tick(); #5 chk("run_default", outs, 7'b1010101);
    tick(); lu_set(5, 5);
    #5 chk("lu_pc_ena", pc_ena, 0);
    chk("lu_if_id_ena", if_id_ena, 0);
    chk("lu_id_ex_x", id_ex_x, 1);
    tick(); idle(); chk("lu_stall_cnt", stall_cnt, 1);
    lu_set(0, 0);
    #5 chk("lu_r0_pc_ena", pc_ena, 1);
    tick(); idle(); chk("lu_r0_stall_cnt", stall_cnt, 1);
    mp_set();
    #5 chk("mp_outs", outs, 7'b1111111);
    tick(); idle(); lu_set(5, 5); chk("mp_flush_cnt", flush_cnt, 1);
    #5 chk("flush1_outs", outs, 7'b1011101);
    tick(); idle(); chk("flush_lu_ignored", stall_cnt, 1);
    #5 chk("flush2_if_id_x", if_id_x, 1);
    tick(); #5 chk("flush_end", outs, 7'b1010101);
    tick(); lu_set(5, 5); mp_set();
    #5 chk("mplu_outs", outs, 7'b1111111);
    tick(); idle(); chk("mplu_stall_cnt", stall_cnt, 1);
    chk("mplu_flush_cnt", flush_cnt, 2);
    repeat (2) tick();
    lu_set(5, 5); mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #5 chk("busy_outs", outs, 0);
      tick();
    end
    mem_busy = 0;
    #5 chk("post_busy_stall", outs, 7'b0000111);
    tick(); idle(); chk("busy_stall_cnt", stall_cnt, 2);
    lu_set(5, 5);
    repeat (20) tick();
    idle(); chk("stall_saturate", stall_cnt, 15);
    mp_set();
    repeat (3) tick();
    idle(); chk("flush_cnt_5", flush_cnt, 5);
    #2 reset_n = 1'b0;
    #1 chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    @(posedge stg_clk); #1 reset_n = 1'b1;
    #5 chk("reinit_outs", outs, 7'b1011111);
    tick(); #5 chk("rerun_default", outs, 7'b1010101);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the pipeline stage latches (fetch/decode, decode/execute, execute/memory). Every cycle it derives each latch's stg_ena (hold) and stg_x (squash to bubble, valid cleared), plus the PC enable and the redirect strobe. It detects three conditions: load-use hazards, branch mispredicts resolved in execute, and data-memory busy. It also keeps saturating stall and flush counters for performance reporting.

Parameters:
FLUSH_HOLD, 1, extra cycles after a mispredict during which fetch/decode keeps loading bubbles (covers instruction-memory latency); legal 0..7
CNT_W, 16, width of the performance counters

Ports:
stg_clk  in  1  pipeline clock, shared with all stage latches
reset_n  in  1  asynchronous, active-low reset
id_valid  in  1  decode-stage instruction valid
id_rs1  in  5  decode rs1
id_rs2  in  5  decode rs2
id_rs1_used  in  1  rs1 read by decode instruction
id_rs2_used  in  1  rs2 read by decode instruction
ex_valid  in  1  execute-stage valid
ex_rd  in  5  execute destination register
ex_rd_memory  in  1  execute instruction is a load
ex_is_branch  in  1  execute instruction is a branch
ex_taken  in  1  resolved branch outcome
ex_prediction  in  1  prediction carried down the pipeline
mem_busy  in  1  data memory not ready; whole pipeline freezes
pc_ena  out  1  PC register load enable
redirect  out  1  PC source select for the resolved target
if_id_ena  out  1  fetch/decode latch enable
if_id_x  out  1  fetch/decode latch squash
id_ex_ena  out  1  decode/execute latch enable
id_ex_x  out  1  decode/execute latch squash
ex_mem_ena  out  1  execute/memory latch enable
stall_cnt  out  CNT_W  saturating count of load-use stall cycles
flush_cnt  out  CNT_W  saturating count of mispredicts

Behaviour:
- Enable and squash outputs are combinational from the current state and inputs. State and counters are registered on the rising edge of stg_clk.
- FSM states: INIT, RUN, FLUSH.
- Reset (reset_n low, asynchronous): state = INIT, flush hold counter = 0, stall_cnt = 0, flush_cnt = 0.
- INIT: lasts exactly one cycle after reset deasserts. Outputs: all enables = 1, if_id_x = 1, id_ex_x = 1, redirect = 0. Next state is RUN.
- Default in RUN: all enables = 1, all squash = 0, redirect = 0.
- Condition lu (load-use): id_valid & ex_valid & ex_rd_memory & ex_rd != 0 & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)).
- Condition mp (mispredict): ex_valid & ex_is_branch & (ex_taken != ex_prediction).
- Priority, highest first: mem_busy, then mp, then lu. Applies in every state.
  - mem_busy: all enables = 0, all squash = 0, redirect = 0. State and counters are frozen; a pending mp or lu is re-evaluated once mem_busy drops.
  - mp: pc_ena = 1, redirect = 1, if_id_x = 1, id_ex_x = 1.
    - Increment flush_cnt, saturating at all-ones.
    - If FLUSH_HOLD = 0, stay in RUN. Otherwise go to FLUSH with hold = FLUSH_HOLD.
    - A concurrent lu is ignored and stall_cnt is not incremented, because the dependent instruction is wrong-path.
  - lu: pc_ena = 0, if_id_ena = 0, id_ex_x = 1 (one bubble into execute). Increment stall_cnt, saturating. State stays RUN.
- FLUSH: if_id_x = 1, all other outputs as in RUN, redirect = 0.
  - Decrement hold each non-frozen cycle; go to RUN in the cycle hold reaches 1.
  - An mp in FLUSH reloads hold to FLUSH_HOLD and increments flush_cnt.
  - An lu in FLUSH is ignored, because the decode stage already holds a bubble.
- A squash has no effect on a latch whose enable is 0. The controller never drives ena = 0 and x = 1 on the same latch.
- Load-use latency is exactly one stall cycle: the next cycle the load is in memory and forwarding is assumed.

Decomposition:
- Shared package pipe_ctrl_pkg: FSM state encoding (INIT = 2'd0, RUN = 2'd1, FLUSH = 2'd2), REG_ZERO = 5'd0, and the priority encoding shared with the forwarding unit.
- One natural sub-module, hazard_detect. It is purely combinational, computes lu and mp, and is reused by the forwarding unit's testbench.

Test Plan:
- Reset/INIT: pulse reset_n low mid-FLUSH with counters at 5 → counters read 0 immediately. The first cycle after release shows if_id_x = 1, id_ex_x = 1; the second cycle shows RUN defaults.
- Load-use: ex_valid = 1, ex_rd_memory = 1, ex_rd = 5; id_valid = 1, id_rs2_used = 1, id_rs2 = 5 → one cycle of pc_ena = 0, if_id_ena = 0, id_ex_x = 1; stall_cnt goes 0 → 1. With ex_rd = 0 → no stall.
- Mispredict with FLUSH_HOLD = 2: ex_is_branch = 1, ex_taken = 1, ex_prediction = 0 → redirect = 1 and both squashes for one cycle, then if_id_x = 1 for 2 more cycles; flush_cnt = 1.
- Simultaneous mp and lu → mispredict response only; stall_cnt unchanged, flush_cnt + 1.
- mem_busy held 3 cycles during an lu → all enables 0 for 3 cycles, then a single stall cycle; stall_cnt + 1, not + 4.
- Saturation with CNT_W = 4: 20 consecutive load-use stalls → stall_cnt holds at 15.
